// File: rtl/start_screen_streamer.sv
// rtl/start_screen_streamer.sv - start-screen ROM raster reader with skid FIFO and valid/ready pixel stream (optional SCALE2X_EN)
module start_screen_streamer #(
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 48,
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    output logic [5:0]  pixel_x,
    output logic [5:0]  pixel_y,
    input  logic [15:0] rom_rgb_data,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        pix_eof,
    output logic        busy,
    output logic        done
);

`ifdef SCALE2X_EN
    localparam int SCALE = 2;
`else
    localparam int SCALE = 1;
`endif
    localparam int OUT_W = IMG_W * SCALE;
    localparam int OUT_H = IMG_H * SCALE;
    localparam int XW    = $clog2(OUT_W);
    localparam int YW    = $clog2(OUT_H);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CNTW  = $clog2(FIFO_DEPTH + 1);
    localparam int EW    = 19;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t                        state_q, state_d;
    logic [XW-1:0]                 ox_q, ox_d;
    logic [YW-1:0]                 oy_q, oy_d;
    logic                          inflight_q, inflight_d;
    logic [2:0]                    tag_q, tag_d;
    logic [FIFO_DEPTH-1:0][EW-1:0] mem_q, mem_d;
    logic [PW-1:0]                 wr_q, wr_d, rd_q, rd_d;
    logic [CNTW-1:0]               count_q, count_d;

    logic          pop;
    logic          issue;
    logic          last_addr;
    logic [CNTW:0] occ;
    logic [EW-1:0] head;

    // ROM address is the output coordinate, halved when each source pixel is doubled
`ifdef SCALE2X_EN
    assign pixel_x = 6'(ox_q >> 1);
    assign pixel_y = 6'(oy_q >> 1);
`else
    assign pixel_x = 6'(ox_q);
    assign pixel_y = 6'(oy_q);
`endif

    assign head      = mem_q[rd_q];
    assign pix_valid = (count_q != '0);
    assign pix_data  = pix_valid ? head[18:3] : 16'h0000;
    assign pix_sof   = pix_valid & head[2];
    assign pix_eol   = pix_valid & head[1];
    assign pix_eof   = pix_valid & head[0];
    assign busy      = (state_q != S_IDLE);

    assign pop       = pix_valid & pix_ready;
    assign last_addr = (ox_q == XW'(OUT_W - 1)) && (oy_q == YW'(OUT_H - 1));
    // Slots already committed: entries held plus the read whose data arrives next edge
    assign occ       = {1'b0, count_q} + (CNTW + 1)'(inflight_q);
    assign issue     = (state_q == S_FETCH) && (occ < ((CNTW + 1)'(FIFO_DEPTH) + (CNTW + 1)'(pop)));

    // Next-state: FSM, address counters, in-flight tracking and FIFO bookkeeping
    always_comb begin
        state_d    = state_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        inflight_d = 1'b0;
        tag_d      = tag_q;
        mem_d      = mem_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        count_d    = count_q;
        done       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_FETCH;
                    ox_d    = '0;
                    oy_d    = '0;
                end
            end
            S_FETCH: begin
                if (issue) begin
                    inflight_d = 1'b1;
                    tag_d      = {(ox_q == '0) && (oy_q == '0), ox_q == XW'(OUT_W - 1), last_addr};
                    if (last_addr) begin
                        state_d = S_DRAIN;
                    end else if (ox_q == XW'(OUT_W - 1)) begin
                        ox_d = '0;
                        oy_d = oy_q + YW'(1);
                    end else begin
                        ox_d = ox_q + XW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if ((count_q == '0) && !inflight_q && !abort) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // ROM data for last cycle's address lands in the FIFO with its markers
        if (inflight_q) begin
            mem_d[wr_q] = {rom_rgb_data, tag_q};
            wr_d        = wr_q + PW'(1);
        end
        if (pop) begin
            rd_d = rd_q + PW'(1);
        end
        count_d = count_q + CNTW'(inflight_q) - CNTW'(pop);

        // Abort drops everything queued or in flight; no completion pulse
        if (abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            inflight_d = 1'b0;
            wr_d       = '0;
            rd_d       = '0;
            count_d    = '0;
            done       = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ox_q       <= '0;
            oy_q       <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
            mem_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
            mem_q      <= mem_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: doc/start_screen_streamer.md
Name: start_screen_streamer

Overview:
- Reader/driver side of the start-screen bitmap ROM (64x48 source, RGB565, 1-cycle registered read latency).
- On a start request it scans every ROM coordinate in raster order and absorbs the ROM read latency.
- Emits pixels as a valid/ready stream toward the LCD/VGA pixel writer, with frame/line markers and a completion pulse.

Parameters:
- IMG_W, 64, source bitmap width in pixels (ROM pixel_x range 0..IMG_W-1).
- IMG_H, 48, source bitmap height in pixels (ROM pixel_y range 0..IMG_H-1).
- FIFO_DEPTH, 2, output skid FIFO entries; fixed at 2, other values unsupported.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  frame request; sampled only in IDLE.
- abort  in  1  synchronous abort of the frame in progress.
- pixel_x  out  6  ROM column address.
- pixel_y  out  6  ROM row address.
- rom_rgb_data  in  16  ROM read data, valid one cycle after the address.
- pix_data  out  16  RGB565 pixel.
- pix_valid  out  1  pix_data and markers valid.
- pix_ready  in  1  downstream accepts the beat when high together with pix_valid.
- pix_sof  out  1  first beat of frame.
- pix_eol  out  1  last beat of a row.
- pix_eof  out  1  last beat of frame.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when a frame completes.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. While reset is active, all outputs are 0, the FIFO is empty, the in-flight flag is clear, and the FSM is in IDLE.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE -> FETCH when start=1. Address counters are cleared and busy goes to 1 on the same edge.
  - FETCH -> DRAIN on the edge that issues the last address (IMG_W-1, IMG_H-1).
  - DRAIN -> IDLE when the FIFO is empty and no read is in flight. done=1 for exactly that one cycle and busy drops to 0.
- Issue:
  - The address on pixel_x/pixel_y is issued in any FETCH cycle where fifo_count + inflight - pop < 2, with pop = pix_valid & pix_ready.
  - After an issue, x increments. At x=IMG_W-1, x wraps to 0 and y increments.
  - When not issuing, the address is held.
- Capture: when inflight=1, rom_rgb_data is written to the FIFO at the next edge, tagged with sof/eol/eof computed from the issued coordinate.
- Latency: the first pix_valid rises 2 cycles after busy rises. With pix_ready held at 1, throughput is 1 beat/clk with no bubbles.
- Stream rules:
  - pix_valid=1 whenever the FIFO is non-empty.
  - While pix_valid & !pix_ready, pix_data and all markers stay stable.
  - pix_valid never drops without a handshake, except on abort or reset.
- Markers:
  - sof only on (0,0).
  - eol on every beat with x=IMG_W-1.
  - eof only on (IMG_W-1, IMG_H-1), which also carries eol.
- start while busy=1 is ignored; no queuing.
- Abort:
  - abort=1 in any busy state flushes the FIFO, clears inflight, and returns to IDLE next edge. done stays 0.
  - abort has priority over start in the same cycle.
  - abort in IDLE has no effect.
- Reset mid-frame gives the full reset state immediately. No partial beat completes after rst_n rises.
- Data rules: pixel coordinates are 6 bits wide. IMG_W and IMG_H must be ≤64; behaviour is undefined otherwise.

Optional Feature:
- Macro: SCALE2X_EN.
- When defined:
  - Output frame is 2*IMG_W x 2*IMG_H (128x96).
  - Output counters ox, oy drive pixel_x=ox>>1 and pixel_y=oy>>1, so each source pixel repeats twice per row and each row repeats twice.
  - Markers are based on output coordinates: eol at ox=2*IMG_W-1, eof at (2*IMG_W-1, 2*IMG_H-1).
  - The ROM is re-read for each repeat; no line buffer.
- When not defined: 1:1 output, IMG_W*IMG_H beats.

Test Plan:
- Reset, then start pulse with pix_ready=1 -> 3072 beats on 3072 consecutive cycles:
  - first beat 2 cycles after busy rises;
  - sof on beat 0, eol on beats 63, 127, ..., 3071, eof on beat 3071;
  - done pulse on the cycle after the last handshake, busy=0 after it.
- Same frame against the ROM model:
  - beat (x=0,y=0)=16'h0000;
  - beat (x=23,y=6)=16'hFFE0 (y*64+x=407);
  - beat (x=5,y=18)=16'hFFE0;
  - beat (x=63,y=47)=16'h0000.
- Random pix_ready (50%) plus pix_ready=0 for 10 cycles mid-row 20 -> pix_data and markers held stable during the stall, no lost or duplicated beats, exactly 3072 handshakes, data matches the model.
- start re-pulsed at beat 100 -> ignored, frame still 3072 beats. abort at beat 1500 -> pix_valid=0 next cycle, no done. Restart -> first beat (0,0) with sof.
- rst_n low for 1 cycle at beat 800 -> all outputs 0 immediately. A new start then produces a clean full frame.
- SCALE2X_EN defined, pix_ready=1 -> 12288 beats; output beats (ox=46, oy=12), (47,12), (46,13), (47,13) all 16'hFFE0; eol every 128 beats; eof on beat 12287.
